fp_accum_seq: RTL and testbench

FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

---
 rtl/fp_accum_seq.sv | 189 ++++++++++++++++++
 tb/tb_fp_accum_seq.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq.sv
//============================================================================
// Module      : fp_accum_seq
// Description : Sequencer that sums N_TERMS IEEE-754 single-precision terms
//               per group by driving an external floating-point adder. The
//               first term of a group loads the accumulator directly; every
//               following term is paired with the running sum and issued to
//               the adder, so each group costs N_TERMS-1 adder operations.
//               This block performs no arithmetic of its own.
//
// Ports       : clk, rst              - clock, synchronous active-high reset
//               strt                  - one-cycle group start (ignored if busy)
//               in_data/in_valid/in_ready - term input handshake
//               add_in1/add_in2/add_strt  - adder operands and start pulse
//               add_busy/add_valid/add_out - adder status and result
//               busy                  - group in progress (LOAD..DONE)
//               valid/out             - one-cycle result pulse, held sum
//
// Parameters  : N_TERMS        - terms per group (2..255)
//               TIMEOUT_CYCLES - adder result timeout (timeout build only)
//
// Build macro : FP_ACCUM_TIMEOUT_EN - when defined, a stalled adder result
//               ends the group after TIMEOUT_CYCLES with a quiet NaN.
//
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_accum_seq #(
    parameter int N_TERMS        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] add_in1,
    output logic [31:0] add_in2,
    output logic        add_strt,
    input  logic        add_busy,
    input  logic        add_valid,
    input  logic [31:0] add_out,
    output logic        busy,
    output logic        valid,
    output logic [31:0] out
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOAD     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_IN  = 3'd2;
    localparam logic [2:0] c_ST_ISSUE    = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RES = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    localparam logic [7:0] c_N_TERMS = 8'(N_TERMS);

    // Reject illegal configurations at elaboration.
    if (N_TERMS < 2 || N_TERMS > 255 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("fp_accum_seq: N_TERMS must be 2..255 and TIMEOUT_CYCLES >= 1");
    end

    logic [2:0]  r_state;
    logic [31:0] r_acc;
    logic [31:0] r_add_in1;
    logic [31:0] r_add_in2;
    logic [31:0] r_out;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_last;

`ifdef FP_ACCUM_TIMEOUT_EN
    // The timer counts WAIT_RES cycles 0..TIMEOUT_CYCLES-1; on the last one
    // without a result the group is abandoned, so DONE lands exactly
    // TIMEOUT_CYCLES cycles after WAIT_RES was entered.
    localparam int                 c_TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]        c_QNAN     = 32'h7FC0_0000;

    logic [c_TMO_W-1:0] r_tmo;
`endif

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_last    = (w_cnt_inc == c_N_TERMS);

    // ------------------------------------------------------------------
    // Control / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_acc     <= '0;
            r_add_in1 <= '0;
            r_add_in2 <= '0;
            r_out     <= '0;
            r_cnt     <= '0;
`ifdef FP_ACCUM_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (strt) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_LOAD;
                    end
                end

                // First term goes straight into the accumulator.
                c_ST_LOAD: begin
                    if (in_valid) begin
                        r_acc   <= in_data;
                        r_cnt   <= 8'd1;
                        r_state <= c_ST_WAIT_IN;
                    end
                end

                // Operands are captured here and stay frozen until the
                // adder result has been consumed.
                c_ST_WAIT_IN: begin
                    if (in_valid) begin
                        r_add_in1 <= r_acc;
                        r_add_in2 <= in_data;
                        r_state   <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    if (!add_busy) begin
                        r_state <= c_ST_WAIT_RES;
`ifdef FP_ACCUM_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end

                // The final adder result is copied into out on the way into
                // DONE, so out already holds the sum during the valid cycle.
                c_ST_WAIT_RES: begin
                    if (add_valid) begin
                        r_acc <= add_out;
                        r_cnt <= w_cnt_inc;
                        if (w_last) begin
                            r_out   <= add_out;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_WAIT_IN;
                        end
                    end
`ifdef FP_ACCUM_TIMEOUT_EN
                    else if (r_tmo == c_TMO_LAST) begin
                        r_out   <= c_QNAN;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready = (r_state == c_ST_LOAD) || (r_state == c_ST_WAIT_IN);
    assign busy     = (r_state != c_ST_IDLE);
    assign valid    = (r_state == c_ST_DONE);
    // Leaving ISSUE is gated by the same condition, so the pulse is one cycle.
    assign add_strt = (r_state == c_ST_ISSUE) && !add_busy;
    assign add_in1  = r_add_in1;
    assign add_in2  = r_add_in2;
    assign out      = r_out;

endmodule

`default_nettype wire

// File: tb/tb_fp_accum_seq.sv
//============================================================================
// Module      : tb_fp_accum_seq
// Description : Self-checking bench for fp_accum_seq. Instance 0 uses
//               N_TERMS=4, instance 1 uses N_TERMS=2. A behavioural adder
//               (latency LAT) serves each instance; expected group sums are
//               queued when a group is started and checked on valid.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_accum_seq;

    localparam int LAT = 4;
    localparam int TMO = 64;

    typedef struct packed {
        logic [3:0][31:0] t;
        logic [31:0]      exp;
        logic [7:0]       gap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt      [2];
    logic [31:0] in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] add_in1   [2];
    logic [31:0] add_in2   [2];
    logic        add_strt  [2];
    logic        add_busy  [2];
    logic        add_valid [2];
    logic [31:0] add_out   [2];
    logic        busy      [2];
    logic        valid     [2];
    logic [31:0] out       [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_accum_seq #(.N_TERMS(4), .TIMEOUT_CYCLES(TMO)) u_dut4 (
        .clk(clk), .rst(rst), .strt(strt[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .add_in1(add_in1[0]),
        .add_in2(add_in2[0]), .add_strt(add_strt[0]), .add_busy(add_busy[0]),
        .add_valid(add_valid[0]), .add_out(add_out[0]), .busy(busy[0]),
        .valid(valid[0]), .out(out[0])
    );

    fp_accum_seq #(.N_TERMS(2), .TIMEOUT_CYCLES(TMO)) u_dut2 (
        .clk(clk), .rst(rst), .strt(strt[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .add_in1(add_in1[1]),
        .add_in2(add_in2[1]), .add_strt(add_strt[1]), .add_busy(add_busy[1]),
        .add_valid(add_valid[1]), .add_out(add_out[1]), .busy(busy[1]),
        .valid(valid[1]), .out(out[1])
    );

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Single <-> double conversion for normal numbers and zero, so the
    // adder model can use real arithmetic.
    function automatic logic [63:0] sp2dp(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        e = 11'(s[30:23]) - 11'd127 + 11'd1023;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] dp2sp(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = $bitstoreal(sp2dp(a));
        rb = $bitstoreal(sp2dp(b));
        return dp2sp($realtobits(ra + rb));
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [31:0] e, input int g);
        vec_t v;
        v.t[0] = a; v.t[1] = b; v.t[2] = c; v.t[3] = d;
        v.exp  = e;
        v.gap  = 8'(g);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Adder model: snapshot at negedge, respond just after posedge
    // ------------------------------------------------------------------
    logic        hold_busy [2];
    logic        mute      [2];
    logic        m_act     [2];
    int          m_cnt     [2];
    logic [31:0] m_res     [2];
    logic        s_go      [2];
    logic [31:0] s_a       [2];
    logic [31:0] s_b       [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            add_busy[k] = 1'b0; add_valid[k] = 1'b0; add_out[k] = '0;
            m_act[k] = 1'b0; m_cnt[k] = 0; m_res[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                s_go[k] = add_strt[k];
                s_a[k]  = add_in1[k];
                s_b[k]  = add_in2[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                add_valid[k] = 1'b0;
                if (m_act[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_act[k] = 1'b0;
                        if (!mute[k]) begin
                            add_valid[k] = 1'b1;
                            add_out[k]   = m_res[k];
                        end
                    end
                end
                if (s_go[k]) begin
                    m_act[k] = 1'b1;
                    m_cnt[k] = LAT;
                    m_res[k] = fadd(s_a[k], s_b[k]);
                end
                add_busy[k] = m_act[k] | hold_busy[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor and scoreboard
    // ------------------------------------------------------------------
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          strt_n [2] = '{0, 0};
    int          xfer_n [2] = '{0, 0};
    int          vcnt   [2] = '{0, 0};
    logic [31:0] cap1   [2];
    logic [31:0] cap2   [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (add_strt[k]) begin
                strt_n[k]++;
                cap1[k] = add_in1[k];
                cap2[k] = add_in2[k];
                chk("add_strt_while_busy", 32'(add_busy[k]), 32'd0);
            end
            if (in_valid[k] && in_ready[k]) xfer_n[k]++;
            if (valid[k]) begin
                vcnt[k]++;
                if (k == 0 && q0.size() > 0)      chk("sum_n4", out[k], q0.pop_front());
                else if (k == 1 && q1.size() > 0) chk("sum_n2", out[k], q1.pop_front());
                else                              chk("unexpected_valid", 32'(valid[k]), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end at posedge+1)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_strt(input int k);
        strt[k] = 1'b1;
        tick();
        strt[k] = 1'b0;
    endtask

    task automatic send_term(input int k, input logic [31:0] d, input int gap);
        bit done = 0;
        in_valid[k] = 1'b0;
        repeat (gap) tick();
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready[k]) done = 1;
        end
        if (!done) chk("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid_neg(input int k);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!valid[k] && c < 300);
        if (!valid[k]) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int k);
        wait_valid_neg(k);
        tick();
    endtask

    task automatic wait_strt(input int k);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!add_strt[k] && c < 100);
        if (!add_strt[k]) chk("add_strt_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t             tbl [5];
    logic [3:0][31:0] tv;
    int               s0, x0, v0;

    initial begin
        tbl[0] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 0);
        tbl[1] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000, 1);
        tbl[2] = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0);
        tbl[3] = mk(32'hBF800000, 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h00000000, 2);
        tbl[4] = mk(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000, 32'h3F700000, 1);

        for (int k = 0; k < 2; k++) begin
            strt[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0;
            hold_busy[k] = 1'b0; mute[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_out",      out[0],             32'd0);
        chk("rst_valid",    32'(valid[0]),      32'd0);
        chk("rst_busy",     32'(busy[0]),       32'd0);
        chk("rst_in_ready", 32'(in_ready[0]),   32'd0);
        chk("rst_add_strt", 32'(add_strt[0]),   32'd0);
        chk("rst_add_in1",  add_in1[0],         32'd0);
        chk("rst_add_in2",  add_in2[0],         32'd0);
        chk("rst_out_n2",   out[1],             32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready[0]), 32'd0);

        // Table-driven groups on the 4-term instance
        for (int v = 0; v < 5; v++) begin
            s0 = strt_n[0]; x0 = xfer_n[0]; v0 = vcnt[0];
            q0.push_back(tbl[v].exp);
            pulse_strt(0);
            chk("busy_in_group", 32'(busy[0]), 32'd1);
            for (int i = 0; i < 4; i++) send_term(0, tbl[v].t[i], int'(tbl[v].gap));
            wait_valid(0);
            chk("busy_after_done", 32'(busy[0]),     32'd0);
            chk("add_ops",         strt_n[0] - s0,   32'd3);
            chk("transfers",       xfer_n[0] - x0,   32'd4);
            chk("valid_pulses",    vcnt[0] - v0,     32'd1);
        end

        // strt during DONE is ignored; strt in the following IDLE cycle starts a group
        q0.push_back(tbl[0].exp);
        pulse_strt(0);
        for (int i = 0; i < 4; i++) send_term(0, tbl[0].t[i], 0);
        wait_valid_neg(0);
        strt[0] = 1'b1;
        tick();
        strt[0] = 1'b0;
        chk("strt_in_done_ignored", 32'(busy[0]), 32'd0);
        q0.push_back(tbl[1].exp);
        pulse_strt(0);
        chk("strt_after_done", 32'(busy[0]), 32'd1);
        for (int i = 0; i < 4; i++) send_term(0, tbl[1].t[i], 0);
        wait_valid(0);

        // Two-term instance: 789 + -655 = 134
        s0 = strt_n[1];
        q1.push_back(32'h43060000);
        pulse_strt(1);
        send_term(1, 32'h44454000, 0);
        send_term(1, 32'hC423C000, 1);
        wait_valid(1);
        chk("n2_add_in1", cap1[1],          32'h44454000);
        chk("n2_add_in2", cap2[1],          32'hC423C000);
        chk("n2_add_ops", strt_n[1] - s0,   32'd1);

        // Adder busy held while the first operation is pending
        hold_busy[0] = 1'b1;
        s0 = strt_n[0];
        q0.push_back(32'h41200000);
        pulse_strt(0);
        send_term(0, 32'h3F800000, 0);
        send_term(0, 32'h40000000, 0);
        repeat (5) tick();
        chk("deferred_no_strt", strt_n[0] - s0, 32'd0);
        chk("held_add_in1",     add_in1[0],     32'h3F800000);
        chk("held_add_in2",     add_in2[0],     32'h40000000);
        hold_busy[0] = 1'b0;
        wait_strt(0);
        tick();
        chk("deferred_one_strt", strt_n[0] - s0, 32'd1);
        chk("deferred_cap1",     cap1[0],        32'h3F800000);
        chk("deferred_cap2",     cap2[0],        32'h40000000);
        send_term(0, 32'h40400000, 0);
        send_term(0, 32'h40800000, 0);
        wait_valid(0);

        // Repeated strt while busy, input valid with gaps
        s0 = strt_n[0]; x0 = xfer_n[0]; v0 = vcnt[0];
        tv = tbl[1].t;
        q0.push_back(32'h41200000);
        pulse_strt(0);
        fork
            begin
                send_term(0, tv[0], 2);
                send_term(0, tv[1], 3);
                send_term(0, tv[2], 1);
                send_term(0, tv[3], 2);
            end
            begin
                repeat (6) begin
                    tick();
                    strt[0] = 1'b1;
                    tick();
                    strt[0] = 1'b0;
                end
            end
        join
        wait_valid(0);
        repeat (5) tick();
        chk("restart_xfers",  xfer_n[0] - x0, 32'd4);
        chk("restart_ops",    strt_n[0] - s0, 32'd3);
        chk("restart_valids", vcnt[0] - v0,   32'd1);
        chk("restart_idle",   32'(busy[0]),   32'd0);

        // Reset while waiting for an adder result; late result must be ignored
        v0 = vcnt[0];
        pulse_strt(0);
        send_term(0, 32'h3F800000, 0);
        send_term(0, 32'h40000000, 0);
        wait_strt(0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("midrst_out",      out[0],           32'd0);
        chk("midrst_busy",     32'(busy[0]),     32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
        chk("midrst_add_in1",  add_in1[0],       32'd0);
        chk("midrst_add_in2",  add_in2[0],       32'd0);
        chk("midrst_add_strt", 32'(add_strt[0]), 32'd0);
        chk("midrst_no_valid", vcnt[0] - v0,     32'd0);

        // Recovery after reset
        q0.push_back(tbl[4].exp);
        pulse_strt(0);
        for (int i = 0; i < 4; i++) send_term(0, tbl[4].t[i], 0);
        wait_valid(0);

`ifdef FP_ACCUM_TIMEOUT_EN
        begin
            int c;
            mute[0] = 1'b1;
            q0.push_back(32'h7FC00000);
            pulse_strt(0);
            send_term(0, 32'h3F800000, 0);
            send_term(0, 32'h40000000, 0);
            wait_strt(0);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!valid[0] && c < TMO + 20);
            chk("timeout_cycles", 32'(c), 32'(TMO + 1));
            tick();
            mute[0] = 1'b0;
            repeat (LAT + 2) tick();
        end
`endif

        chk("queue_n4_empty", 32'(q0.size()), 32'd0);
        chk("queue_n2_empty", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
